ir_frame_tx: RTL and testbench
==============================

IR_FRAME_TX -- requirements
Module: ir_frame_tx

Interface
REQ-001 SHALL take parameter TICK_DIV, default 6250, meaning sys_clk cycles per protocol tick (0.125 ms at 50 MHz).
REQ-002 SHALL take parameter GAP_TICKS, default 2100, meaning the minimum idle-high ticks after a frame before the next frame is accepted.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock.
REQ-004 SHALL have port sys_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tx_valid, input, 1 bit: a command byte is offered.
REQ-006 SHALL have port tx_data, input, 8 bits: the command byte.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block can accept a byte.
REQ-008 SHALL have port ir_out, output, 1 bit: the encoded IR line, idle high, registered.
REQ-009 SHALL have port tx_busy, output, 1 bit: a frame or guard gap is in progress.
REQ-010 SHALL have port frame_done, output, 1 bit: a one-cycle pulse when the guard gap ends.

Function
REQ-011 SHALL accept a byte on any sys_clk edge where tx_valid && tx_ready are both high; tx_ready is high only in IDLE.
REQ-012 SHALL latch the 16-bit shift word {~tx_data, tx_data} on acceptance and transmit it MSB first, so the complement byte goes first and the true byte last.
REQ-013 SHALL clear the tick prescaler on acceptance; a tick strobe fires every TICK_DIV sys_clk cycles after that.
REQ-014 SHALL drive ir_out low on the cycle after acceptance; all later level changes occur on the cycle after a tick strobe.
REQ-015 SHALL step through these states, with ticks counted per state:
  - IDLE: ir_out high
  - START_L: low, 24 ticks
  - START_H: high, 24 ticks
  - BIT_L: low, 4 ticks
  - BIT_H: high, 12 ticks for a 0 bit or 20 ticks for a 1 bit
  - STOP_L: low, 4 ticks
  - SYNC_H: high, 28 ticks
  - END_L: low, 4 ticks
  - GAP: high, GAP_TICKS ticks
  - then back to IDLE
REQ-016 SHALL repeat BIT_L/BIT_H 16 times using a 5-bit bit counter; after the 16th BIT_H it SHALL go to STOP_L.
REQ-017 SHALL keep every frame at exactly 404 ticks from START_L to the end of END_L, because the complement pairing guarantees eight 1 bits per frame.
REQ-018 SHALL use a 12-bit tick counter sized for GAP_TICKS; it resets to 0 on every state change, and there is no wrap-around inside any state.
REQ-019 SHALL hold tx_busy high from acceptance through the end of GAP.
REQ-020 SHALL assert frame_done for exactly one cycle at the GAP-to-IDLE transition; tx_ready rises in that same cycle.
REQ-021 SHALL ignore tx_valid and tx_data while tx_busy is high; no queuing, no corruption of the frame in flight.
REQ-022 SHALL accept a new byte on the first cycle tx_ready is high if tx_valid is already high then (back-to-back frames, gap preserved).
REQ-023 SHALL fall back to IDLE with ir_out high if the state register ever reaches an illegal encoding.

Reset
REQ-024 SHALL, on sys_rst, asynchronously force the state to IDLE and set ir_out=1, tx_ready=1, tx_busy=0, frame_done=0, all counters=0 and shift word=0.
REQ-025 SHALL abandon the frame if reset hits mid-frame, with ir_out high immediately; after release, no partial frame resumes and the next accepted byte starts a fresh frame.

Structure
REQ-026 SHALL take the timing constants (24, 24, 4, 12, 20, 4, 28, 4, default gap) and the state encoding from the shared package ir_pkg, which the receive side also uses.
REQ-027 SHALL put the prescaler in a sub-module ir_tick_gen (inputs sys_clk, sys_rst, clr; output tick), instantiated once.

Verification
REQ-028 SHALL be verified as follows: reset, then tx_data=0xA5 with tx_valid for 1 cycle -> ir_out low 24 ticks, high 24, then the high widths 12,20,12,20,20,12,20,12,20,12,20,12,12,20,12,20 ticks, then low 4, high 28, low 4; the frame is 2,525,000 sys_clk cycles.
REQ-029 SHALL be verified as follows: 0x00 and 0xFF are each 404 ticks; 0x00 gives eight 20-tick highs then eight 12-tick highs; 0xFF gives the reverse.
REQ-030 SHALL be verified as follows: tx_valid held high with 0x3C then 0xC3 -> two frames, ir_out high for at least 2100 ticks between END_L and the next START_L, and frame_done pulses once per frame.
REQ-031 SHALL be verified as follows: tx_data changed and tx_valid pulsed during BIT_H -> the waveform is unchanged and tx_ready stays 0.
REQ-032 SHALL be verified as follows: sys_rst asserted mid-SYNC_H -> ir_out=1 in the same cycle and tx_ready=1; after release, 0x12 produces a complete, correct frame.
REQ-033 SHALL be verified as follows: loopback through the IR receiver with 0x5E -> the receiver pulses data_en once with data=0x5E.

Source files
------------

// File: rtl/ir_pkg.sv
// ir_pkg -- shared definitions for the IR frame transmitter and receiver.
//
// Holds the protocol timing constants (in protocol ticks), the FSM state
// encoding and small helpers that map a state to its line level, its
// duration and its successor. Both sides of the link import this package,
// so a timing change here applies to the transmitter and the receiver.
package ir_pkg;

  // Default prescaler: 6250 sys_clk cycles = 0.125 ms per tick at 50 MHz.
  localparam int unsigned TICK_DIV_DEF  = 6250;
  // Default idle-high guard time after each frame, in ticks.
  localparam int unsigned GAP_TICKS_DEF = 2100;

  // The tick counter must hold the longest state, which is the guard gap.
  localparam int unsigned TICK_CNT_W = 12;
  // Five bits so the counter can express the full 16-bit payload length.
  localparam int unsigned BIT_CNT_W  = 5;
  localparam int unsigned FRAME_BITS = 16;

  // Segment durations in ticks.
  localparam logic [TICK_CNT_W-1:0] START_L_TICKS = 12'd24;
  localparam logic [TICK_CNT_W-1:0] START_H_TICKS = 12'd24;
  localparam logic [TICK_CNT_W-1:0] BIT_L_TICKS   = 12'd4;
  localparam logic [TICK_CNT_W-1:0] BIT0_H_TICKS  = 12'd12;
  localparam logic [TICK_CNT_W-1:0] BIT1_H_TICKS  = 12'd20;
  localparam logic [TICK_CNT_W-1:0] STOP_L_TICKS  = 12'd4;
  localparam logic [TICK_CNT_W-1:0] SYNC_H_TICKS  = 12'd28;
  localparam logic [TICK_CNT_W-1:0] END_L_TICKS   = 12'd4;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START_L = 4'd1,
    S_START_H = 4'd2,
    S_BIT_L   = 4'd3,
    S_BIT_H   = 4'd4,
    S_STOP_L  = 4'd5,
    S_SYNC_H  = 4'd6,
    S_END_L   = 4'd7,
    S_GAP     = 4'd8
  } ir_state_e;

  // Number of ticks a state lasts. A BIT_H segment length carries the bit
  // value; the guard gap is a module parameter so it is passed in.
  function automatic logic [TICK_CNT_W-1:0] state_ticks(
    input ir_state_e              s,
    input logic                   bit_val,
    input logic [TICK_CNT_W-1:0]  gap_ticks
  );
    logic [TICK_CNT_W-1:0] t;
    t = '0;
    case (s)
      S_START_L: t = START_L_TICKS;
      S_START_H: t = START_H_TICKS;
      S_BIT_L:   t = BIT_L_TICKS;
      S_BIT_H:   t = bit_val ? BIT1_H_TICKS : BIT0_H_TICKS;
      S_STOP_L:  t = STOP_L_TICKS;
      S_SYNC_H:  t = SYNC_H_TICKS;
      S_END_L:   t = END_L_TICKS;
      S_GAP:     t = gap_ticks;
      default:   t = '0;
    endcase
    return t;
  endfunction

  // Line level driven while in a state: low segments are the marks.
  function automatic logic state_level(input ir_state_e s);
    logic lvl;
    case (s)
      S_START_L, S_BIT_L, S_STOP_L, S_END_L: lvl = 1'b0;
      default:                                lvl = 1'b1;
    endcase
    return lvl;
  endfunction

  // Successor of a timed state once its duration has elapsed. IDLE leaves
  // only on an accepted byte, which the FSM handles itself.
  function automatic ir_state_e next_state(
    input ir_state_e s,
    input logic      last_bit
  );
    ir_state_e n;
    case (s)
      S_START_L: n = S_START_H;
      S_START_H: n = S_BIT_L;
      S_BIT_L:   n = S_BIT_H;
      S_BIT_H:   n = last_bit ? S_STOP_L : S_BIT_L;
      S_STOP_L:  n = S_SYNC_H;
      S_SYNC_H:  n = S_END_L;
      S_END_L:   n = S_GAP;
      S_GAP:     n = S_IDLE;
      default:   n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// ir_tick_gen -- protocol tick prescaler.
//
// Counts sys_clk cycles and raises tick for one cycle every TICK_DIV cycles.
// clr restarts the count so the first tick after a clear lands exactly
// TICK_DIV cycles after the clearing edge, which keeps frame timing aligned
// to the byte acceptance.
//
// Ports:
//   sys_clk  in   clock
//   sys_rst  in   asynchronous active-high reset
//   clr      in   restart the prescaler on this edge
//   tick     out  one-cycle strobe, every TICK_DIV cycles
module ir_tick_gen #(
  parameter int unsigned TICK_DIV = 6250
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clr || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A clear wins over a coincident strobe so no stale tick reaches a frame
  // that starts on this edge.
  assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/ir_frame_tx.sv
// ir_frame_tx -- pulse-distance IR frame transmitter.
//
// Accepts one command byte and sends it as a 16-bit word {~data, data},
// MSB first: a 24-tick low / 24-tick high start, sixteen bits each made of
// a 4-tick low mark followed by a 12-tick (0) or 20-tick (1) space, then a
// 4-tick stop mark, a 28-tick sync space and a 4-tick end mark. Because the
// complement is sent alongside the byte, every frame has exactly eight 1
// bits and lasts 404 ticks. A GAP_TICKS idle-high guard follows each frame
// before the next byte is accepted.
//
// Handshake: a byte is taken on any sys_clk edge where tx_valid && tx_ready.
// tx_ready is high only while idle; tx_valid/tx_data are ignored otherwise,
// and the source must hold them until that edge.
//
// Ports:
//   sys_clk     in   clock
//   sys_rst     in   asynchronous active-high reset
//   tx_valid    in   command byte offered
//   tx_data     in   command byte [7:0]
//   tx_ready    out  block idle and able to accept a byte (registered)
//   ir_out      out  encoded IR line, idle high (registered)
//   tx_busy     out  frame or guard gap in progress (registered)
//   frame_done  out  one-cycle pulse as the guard gap ends (registered)
module ir_frame_tx
  import ir_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
  parameter int unsigned GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       ir_out,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam logic [TICK_CNT_W-1:0] GAP_LEN = TICK_CNT_W'(GAP_TICKS);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT_IDX = BIT_CNT_W'(FRAME_BITS - 1);

  ir_state_e              state;
  ir_state_e              nxt;
  logic [TICK_CNT_W-1:0]  tick_cnt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [15:0]            shift_word;
  logic [TICK_CNT_W-1:0]  seg_ticks;
  logic                   seg_last;
  logic                   last_bit;
  logic                   accept;
  logic                   tick;

  assign accept = tx_valid && tx_ready;

  ir_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (accept),
    .tick    (tick)
  );

  // The bit on the wire is always the MSB of the shift word; it sets the
  // length of the current BIT_H space.
  always_comb begin
    seg_ticks = state_ticks(state, shift_word[15], GAP_LEN);
    seg_last  = (tick_cnt == (seg_ticks - 1'b1));
    last_bit  = (bit_cnt == LAST_BIT_IDX);
    nxt       = next_state(state, last_bit);
  end

  // Level changes are registered on the edge that consumes the tick strobe,
  // so every segment is an exact multiple of TICK_DIV cycles long.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      ir_out     <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift_word <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          ir_out   <= 1'b1;
          tx_ready <= 1'b1;
          tx_busy  <= 1'b0;
          tick_cnt <= '0;
          if (accept) begin
            state      <= S_START_L;
            ir_out     <= 1'b0;
            tx_ready   <= 1'b0;
            tx_busy    <= 1'b1;
            bit_cnt    <= '0;
            shift_word <= {~tx_data, tx_data};
          end
        end

        S_START_L, S_START_H, S_BIT_L, S_BIT_H,
        S_STOP_L, S_SYNC_H, S_END_L, S_GAP: begin
          if (tick) begin
            if (seg_last) begin
              tick_cnt <= '0;
              state    <= nxt;
              ir_out   <= state_level(nxt);
              if (state == S_BIT_H) begin
                shift_word <= {shift_word[14:0], 1'b0};
                bit_cnt    <= bit_cnt + 1'b1;
              end
              if (state == S_GAP) begin
                tx_ready   <= 1'b1;
                tx_busy    <= 1'b0;
                frame_done <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        // Unreachable encodings recover to a clean idle line.
        default: begin
          state      <= S_IDLE;
          ir_out     <= 1'b1;
          tx_ready   <= 1'b1;
          tx_busy    <= 1'b0;
          tick_cnt   <= '0;
          bit_cnt    <= '0;
          shift_word <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_frame_tx.sv
// Testbench for ir_frame_tx, built with a short tick and guard gap so whole
// frames fit in a brief run.
module tb_ir_frame_tx;

  localparam int unsigned TD        = 5;
  localparam int unsigned GAP       = 30;
  localparam int unsigned RUN_LIMIT = 64 * TD;
  localparam int unsigned WAIT_MAX  = 20000;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ir_out;
  logic       tx_busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_wide = 0;
  bit mon_busy = 1'b0;

  // Each entry: {expected 16-bit wire word, expected decoded byte}.
  logic [23:0] exp_q[$];

  ir_frame_tx #(
    .TICK_DIV  (TD),
    .GAP_TICKS (GAP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ir_out     (ir_out),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- compare helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < WAIT_MAX) begin
      @(negedge sys_clk);
      n++;
    end
    check("wait_ready", tx_ready, 1);
  endtask

  // Called at a negedge; returns #1 after the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input logic [15:0] word);
    wait_ready();
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back({word, b});
    @(posedge sys_clk);
    #1;
    tx_valid = 1'b0;
    check("accept_ready_busy_ir", {29'd0, tx_ready, tx_busy, ir_out}, 32'b010);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !mon_busy && tx_ready === 1'b1) && n < WAIT_MAX) begin
      @(negedge sys_clk);
      n++;
    end
    check("drain_timeout", (n < WAIT_MAX) ? 1 : 0, 1);
    repeat (3) @(negedge sys_clk);
  endtask

  // ---------------- monitor ----------------
  // Length in cycles of the current ir_out level, counting the sample that
  // started it; exits on the first sample of the next level.
  task automatic measure_run(input logic lvl, output int len, output bit aborted);
    len = 1;
    aborted = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst === 1'b1) begin
        aborted = 1'b1;
        return;
      end
      if (ir_out !== lvl || len >= RUN_LIMIT) return;
      len++;
    end
  endtask

  task automatic watch_frame(input logic [23:0] e);
    int len, total, gap_cnt, gap_low;
    bit ab;
    logic [15:0] word, got;
    logic [7:0] inv;
    word  = e[23:8];
    got   = '0;
    total = 0;
    measure_run(1'b0, len, ab); if (ab) return;
    total += len; check("start_l_cycles", len, 24 * TD);
    measure_run(1'b1, len, ab); if (ab) return;
    total += len; check("start_h_cycles", len, 24 * TD);
    for (int i = 0; i < 16; i++) begin
      measure_run(1'b0, len, ab); if (ab) return;
      total += len; check("bit_l_cycles", len, 4 * TD);
      measure_run(1'b1, len, ab); if (ab) return;
      total += len; check("bit_h_cycles", len, word[15-i] ? 20 * TD : 12 * TD);
      got[15-i] = (len >= 16 * TD);
    end
    measure_run(1'b0, len, ab); if (ab) return;
    total += len; check("stop_l_cycles", len, 4 * TD);
    measure_run(1'b1, len, ab); if (ab) return;
    total += len; check("sync_h_cycles", len, 28 * TD);
    measure_run(1'b0, len, ab); if (ab) return;
    total += len; check("end_l_cycles", len, 4 * TD);
    check("frame_cycles", total, 404 * TD);
    // Receiver-style decode: complement pairing validates the byte.
    inv = ~got[7:0];
    check("rx_complement", got[15:8], inv);
    check("rx_data", got[7:0], e[7:0]);
    // Guard gap: line high until frame_done, which must come GAP ticks on.
    gap_cnt = 0;
    gap_low = 0;
    while (frame_done !== 1'b1 && gap_cnt < GAP * TD + 50) begin
      @(negedge sys_clk);
      if (sys_rst === 1'b1) return;
      if (ir_out !== 1'b1) gap_low++;
      gap_cnt++;
    end
    check("gap_cycles", gap_cnt, GAP * TD);
    check("gap_low_samples", gap_low, 0);
    check("done_ready_busy", {30'd0, tx_ready, tx_busy}, 32'b10);
  endtask

  initial begin : monitor
    logic [23:0] e;
    forever begin
      mon_busy = 1'b0;
      @(negedge sys_clk);
      if (sys_rst === 1'b1 || ir_out !== 1'b0) continue;
      mon_busy = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      watch_frame(e);
    end
  end

  initial begin : done_counter
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (frame_done === 1'b1) begin
        if (prev) done_wide++;
        else done_cnt++;
      end
      prev = (frame_done === 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n, rises;
    logic prev_ir;
    sys_rst  = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_ir_out", ir_out, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_frame_done", frame_done, 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // Reference frame and the two extreme bytes.
    send_byte(8'hA5, 16'h5AA5); wait_drain();
    send_byte(8'h00, 16'hFF00); wait_drain();
    send_byte(8'hFF, 16'h00FF); wait_drain();

    // Back-to-back: tx_valid never drops; the second byte must go on the
    // first ready cycle, after a full guard gap.
    wait_ready();
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    exp_q.push_back({16'hC33C, 8'h3C});
    @(posedge sys_clk);
    #1;
    check("b2b_first_accept", tx_ready, 0);
    tx_data = 8'hC3;
    exp_q.push_back({16'h3CC3, 8'hC3});
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (tx_ready !== 1'b1 && n < WAIT_MAX);
    check("b2b_ready_seen", tx_ready, 1);
    @(posedge sys_clk);
    #1;
    check("b2b_second_accept", {30'd0, tx_ready, tx_busy}, 32'b01);
    tx_valid = 1'b0;
    wait_drain();

    // Input activity during BIT_H must not disturb the frame in flight.
    send_byte(8'h96, 16'h6996);
    rises   = 0;
    prev_ir = 1'b0;
    n       = 0;
    while (rises < 2 && n < WAIT_MAX) begin
      @(negedge sys_clk);
      if (ir_out === 1'b1 && !prev_ir) rises++;
      prev_ir = ir_out;
      n++;
    end
    check("reach_bit_h", rises, 2);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    check("busy_ignores_ready", tx_ready, 0);
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    wait_drain();

    // Reset in the middle of SYNC_H (which starts 372 ticks in).
    send_byte(8'h77, 16'h8877);
    repeat (372 * TD + 10) @(negedge sys_clk);
    #2;
    sys_rst = 1'b1;
    #1;
    check("midrst_ir_out", ir_out, 1);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_tx_busy", tx_busy, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    send_byte(8'h12, 16'hED12); wait_drain();

    // Loopback decode of one more byte.
    send_byte(8'h5E, 16'hA15E); wait_drain();

    repeat (20) @(negedge sys_clk);
    check("frames_completed", done_cnt, 8);
    check("done_pulse_wide", done_wide, 0);
    check("exp_q_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
